// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the 8N1 UART transmitter.
//   tx_state_t - transmitter FSM states
//   DATA_BITS  - payload bits per frame
//   FRAME_BITS - start + data + stop bits per frame
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-request / serial-output bundle between a producer and uart_tx.
//   i_Tx_DV     producer -> tx  one-cycle request strobe
//   i_Tx_Byte   producer -> tx  byte to send, valid with i_Tx_DV
//   o_Tx_Active tx -> producer  high while a frame is on the line
//   o_Tx_Serial tx -> pin       serial line, idles high
//   o_Tx_Done   tx -> producer  one-cycle pulse at frame completion
// master = producer side, slave = transmitter side.
interface uart_tx_if;
    import uart_pkg::*;

    logic                 i_Tx_DV;
    logic [DATA_BITS-1:0] i_Tx_Byte;
    logic                 o_Tx_Active;
    logic                 o_Tx_Serial;
    logic                 o_Tx_Done;

    modport master (
        output i_Tx_DV,
        output i_Tx_Byte,
        input  o_Tx_Active,
        input  o_Tx_Serial,
        input  o_Tx_Done
    );

    modport slave (
        input  i_Tx_DV,
        input  i_Tx_Byte,
        output o_Tx_Active,
        output o_Tx_Serial,
        output o_Tx_Done
    );

endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART serial transmitter.
// Accepts one byte per i_Tx_DV strobe (only while idle) and shifts out a start
// bit, 8 data bits LSB first and a stop bit, each held CLKS_PER_BIT clocks.
// Ports:
//   i_Clock  system clock, rising edge
//   i_Reset  synchronous active-high reset; aborts any frame without Done
//   tx       uart_tx_if.slave: i_Tx_DV/i_Tx_Byte in, o_Tx_Active/o_Tx_Serial/o_Tx_Done out
// Parameter:
//   CLKS_PER_BIT  clocks per serial bit (>= 2)
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    uart_tx_if.slave   tx
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    tx_state_t            state;
    logic [CNT_W-1:0]     count;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] data;
    logic                 bit_end;
    logic [2:0]           next_idx;

    assign bit_end  = (count == CNT_LAST);
    assign next_idx = bit_idx + 3'd1;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state          <= IDLE;
            count          <= '0;
            bit_idx        <= '0;
            data           <= '0;
            tx.o_Tx_Serial <= 1'b1;
            tx.o_Tx_Active <= 1'b0;
            tx.o_Tx_Done   <= 1'b0;
        end else begin
            tx.o_Tx_Done <= 1'b0;
            case (state)
                IDLE: begin
                    count          <= '0;
                    bit_idx        <= '0;
                    tx.o_Tx_Serial <= 1'b1;
                    tx.o_Tx_Active <= 1'b0;
                    if (tx.i_Tx_DV) begin
                        data           <= tx.i_Tx_Byte;
                        tx.o_Tx_Serial <= 1'b0;
                        tx.o_Tx_Active <= 1'b1;
                        state          <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        count          <= '0;
                        tx.o_Tx_Serial <= data[0];
                        state          <= DATA;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        count <= '0;
                        // Line is registered, so the next bit is loaded at the
                        // boundary edge rather than decoded from bit_idx.
                        if (bit_idx == IDX_LAST) begin
                            bit_idx        <= '0;
                            tx.o_Tx_Serial <= 1'b1;
                            state          <= STOP;
                        end else begin
                            bit_idx        <= next_idx;
                            tx.o_Tx_Serial <= data[next_idx];
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        count          <= '0;
                        tx.o_Tx_Done   <= 1'b1;
                        tx.o_Tx_Active <= 1'b0;
                        state          <= CLEANUP;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                CLEANUP: begin
                    tx.o_Tx_Serial <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with CLKS_PER_BIT = 10.
// Expected bytes are queued when a request is driven and popped when the
// frame is checked cycle by cycle on the falling clock edge.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int C = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] exp_q[$];

    uart_tx_if bus ();

    uart_tx #(.CLKS_PER_BIT(C)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .tx      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_serial_%0d", tag, i), bus.o_Tx_Serial, 1'b1);
            check($sformatf("%s_active_%0d", tag, i), bus.o_Tx_Active, 1'b0);
            check($sformatf("%s_done_%0d", tag, i), bus.o_Tx_Done, 1'b0);
            @(negedge clk);
        end
    endtask

    function automatic logic line_bit(input logic [7:0] b, input int t);
        int pos;
        pos = t / C;
        if (pos == 0) return 1'b0;
        if (pos <= int'(DATA_BITS)) return b[pos-1];
        return 1'b1;
    endfunction

    // Drive one request on the current falling edge, then check each cycle.
    // glitch_at: cycle index at which a stray 0x3C request is pulsed (-1 none)
    // reset_at : cycle index at which reset is pulsed for one cycle (-1 none)
    task automatic run_frame(input logic [7:0] b, input int glitch_at, input int reset_at);
        logic [7:0] exp;
        bus.i_Tx_DV   = 1'b1;
        bus.i_Tx_Byte = b;
        exp_q.push_back(b);
        @(negedge clk);
        bus.i_Tx_DV   = 1'b0;
        bus.i_Tx_Byte = ~b;
        exp = exp_q.pop_front();
        for (int t = 0; t <= int'(FRAME_BITS) * C + 1; t++) begin
            if (reset_at >= 0 && t == reset_at + 1) begin
                rst = 1'b0;
                check_idle($sformatf("abort_%02h", exp), C * int'(FRAME_BITS) + 5);
                return;
            end
            if (t < int'(FRAME_BITS) * C) begin
                check($sformatf("f%02h_serial_t%0d", exp, t), bus.o_Tx_Serial, line_bit(exp, t));
                check($sformatf("f%02h_active_t%0d", exp, t), bus.o_Tx_Active, 1'b1);
                check($sformatf("f%02h_done_t%0d", exp, t), bus.o_Tx_Done, 1'b0);
            end else begin
                check($sformatf("f%02h_serial_t%0d", exp, t), bus.o_Tx_Serial, 1'b1);
                check($sformatf("f%02h_active_t%0d", exp, t), bus.o_Tx_Active, 1'b0);
                check($sformatf("f%02h_done_t%0d", exp, t), bus.o_Tx_Done,
                      (t == int'(FRAME_BITS) * C) ? 1'b1 : 1'b0);
            end
            bus.i_Tx_DV = 1'b0;
            if (t == glitch_at) begin
                bus.i_Tx_DV   = 1'b1;
                bus.i_Tx_Byte = 8'h3C;
            end
            if (t == reset_at) rst = 1'b1;
            if (t == int'(FRAME_BITS) * C + 1) break;
            @(negedge clk);
        end
    endtask

    initial begin
        bus.i_Tx_DV   = 1'b0;
        bus.i_Tx_Byte = 8'h00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_serial", bus.o_Tx_Serial, 1'b1);
        check("reset_active", bus.o_Tx_Active, 1'b0);
        check("reset_done", bus.o_Tx_Done, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_idle("idle", 20);

        run_frame(8'hA5, -1, -1);
        check_idle("gap1", 3);

        // Back-to-back: each request issued the cycle after Done.
        run_frame(8'h00, -1, -1);
        run_frame(8'hFF, -1, -1);
        check_idle("gap2", 3);

        run_frame(8'hA5, 35, -1);
        check_idle("after_glitch", 3);

        run_frame(8'hA5, -1, 45);
        run_frame(8'h5A, -1, -1);
        run_frame(8'hC3, -1, -1);
        check_idle("gap3", 3);

        // Request together with reset is dropped.
        bus.i_Tx_DV   = 1'b1;
        bus.i_Tx_Byte = 8'h81;
        rst = 1'b1;
        @(negedge clk);
        bus.i_Tx_DV = 1'b0;
        rst = 1'b0;
        check_idle("dv_with_reset", 20);

        check("scoreboard_empty", exp_q.size() == 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
